// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the memory size, NOP encoding, FSM states and the fetch-entry bundle.
// Build option FETCH_SEQUENCER_BOUNDS_CHECK_EN adds the FAULT state.
package mips_fetch_pkg;

    // Instruction memory depth in 32-bit words.
    localparam int unsigned IMEM_WORDS = 256;

    // First byte address past the end of instruction memory.
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

    // addi $0,$0,0; used as filler in empty buffer slots.
    localparam logic [31:0] NOP = 32'h2000_0000;

`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } fetch_state_t;
`else
    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;
`endif

    // One buffered fetch: the word read and the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Clear the byte-offset bits of an address.
    function automatic logic [31:0] align_word(
        input logic [31:0] addr
    );
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of {instruction, pc} pairs between fetch and decode.
// Ports: clk, rst_n (sync, active-low), push/din, pop, flush, head, count.
module fetch_buffer
    import mips_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t din,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    localparam fetch_entry_t EMPTY = '{instr: NOP, pc: 32'd0};

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   cnt;
    logic         do_pop;
    logic         do_push;

    // Ignore requests the buffer cannot honour (pop empty, push full).
    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= 2'd0;
            slot0 <= EMPTY;
            slot1 <= EMPTY;
        end else if (flush) begin
            cnt <= 2'd0;
        end else begin
            unique case ({do_push, do_pop})
                2'b11: begin
                    // Count unchanged; new entry lands behind survivor.
                    if (cnt == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    // Only shift when a second entry exists so the
                    // head stays put once the buffer empties.
                    if (cnt == 2'd2) begin
                        slot0 <= slot1;
                    end
                    cnt <= cnt - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC register, RUN/HALTED(/FAULT) FSM and 2-entry buffer.
// Ports: Clk, Reset_n (sync, active-low); ImemAddress/ImemInstruction to
// instruction memory; RedirectValid/RedirectTarget from execute; Halt;
// InstrValid/InstrReady/Instruction/InstrPC to decode; BufCount; Fault.
// Build option FETCH_SEQUENCER_BOUNDS_CHECK_EN enables the range fault.
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
)
(
    input  logic        Clk,
    input  logic        Reset_n,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Halt,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic [1:0]  BufCount,
    output logic        Fault
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [1:0]   count;
    fetch_entry_t head;
    fetch_entry_t fetch_in;
    logic         pop;
    logic         slot_free;
    logic         fetch_try;
    logic         push;

    assign InstrValid = (count != 2'd0);
    assign pop        = InstrValid && InstrReady;

    // A slot is free if one is empty or the head leaves this cycle.
    assign slot_free = (count != 2'd2) || pop;

    // Halt gates fetch in the cycle it rises; redirect wins outright.
    assign fetch_try = (state == ST_RUN) && !Halt &&
                       !RedirectValid && slot_free;

`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
    logic oob;
    logic fault_q;

    assign oob   = (pc >= IMEM_LIMIT);
    assign push  = fetch_try && !oob;
    assign Fault = fault_q;
`else
    assign push  = fetch_try;
    assign Fault = 1'b0;
`endif

    assign fetch_in = '{instr: ImemInstruction, pc: pc};

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            if (RedirectValid) begin
                pc <= align_word(RedirectTarget);
            end else if (push) begin
                pc <= pc + 32'd4;
            end

            unique case (1'b1)
                (state == ST_RUN): begin
`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
                    if (fetch_try && oob) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (Halt) begin
                        state <= ST_HALTED;
                    end
`else
                    if (Halt) begin
                        state <= ST_HALTED;
                    end
`endif
                end
                (state == ST_HALTED): begin
                    if (!Halt) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    // FAULT is left only through reset.
                end
            endcase
        end
    end

    fetch_buffer u_buf (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (push),
        .din   (fetch_in),
        .pop   (pop),
        .flush (RedirectValid),
        .head  (head),
        .count (count)
    );

    assign ImemAddress = pc;
    assign Instruction = head.instr;
    assign InstrPC     = head.pc;
    assign BufCount    = count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// traffic against a queue-based reference model of the fetch front end.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'd0;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Halt;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instruction;
    logic [31:0] InstrPC;
    logic [1:0]  BufCount;
    logic        Fault;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2000_0000;
    endfunction

    assign ImemInstruction = mem_word(ImemAddress);

    fetch_sequencer #(.RESET_PC(RST_PC)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .RedirectValid   (RedirectValid),
        .RedirectTarget  (RedirectTarget),
        .Halt            (Halt),
        .InstrValid      (InstrValid),
        .InstrReady      (InstrReady),
        .Instruction     (Instruction),
        .InstrPC         (InstrPC),
        .BufCount        (BufCount),
        .Fault           (Fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the driven inputs.
    task automatic model_update();
        int n;
        bit pop;
        bit may_fetch;
        bit oob;
        n = mq_pc.size();
        pop = (n != 0) && InstrReady;
        if (!Reset_n) begin
            mq_pc.delete();
            mq_ins.delete();
            m_pc = RST_PC;
            m_halted = 0;
            m_fault = 0;
            return;
        end
        may_fetch = !m_halted && !m_fault && !Halt && !RedirectValid &&
                    ((n < 2) || pop);
        if (pop) begin
            void'(mq_pc.pop_front());
            void'(mq_ins.pop_front());
        end
        if (RedirectValid) begin
            mq_pc.delete();
            mq_ins.delete();
            m_pc = RedirectTarget & 32'hFFFF_FFFC;
        end else if (may_fetch) begin
            oob = 0;
`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
            oob = (m_pc >= 32'd1024);
`endif
            if (oob) begin
                m_fault = 1;
            end else begin
                mq_pc.push_back(m_pc);
                mq_ins.push_back(mem_word(m_pc));
                m_pc = m_pc + 32'd4;
            end
        end
        if (!m_fault) m_halted = Halt;
    endtask

    task automatic check_all();
        int n;
        n = mq_pc.size();
        chk("valid", 32'(InstrValid), 32'(n != 0));
        chk("bufcount", 32'(BufCount), 32'(n));
        chk("imem_addr", ImemAddress, m_pc);
        chk("fault", 32'(Fault), 32'(m_fault));
        if (n != 0) begin
            chk("instr", Instruction, mq_ins[0]);
            chk("instr_pc", InstrPC, mq_pc[0]);
        end
    endtask

    task automatic step(input bit rn, input bit ry, input bit hl,
                        input bit rv, input logic [31:0] tg);
        Reset_n        = rn;
        InstrReady     = ry;
        Halt           = hl;
        RedirectValid  = rv;
        RedirectTarget = tg;
        @(posedge Clk);
        model_update();
        @(negedge Clk);
        check_all();
    endtask

    initial begin
        logic [31:0] frozen;
        bit hl;
        Reset_n = 0;
        InstrReady = 0;
        Halt = 0;
        RedirectValid = 0;
        RedirectTarget = '0;
        m_pc = RST_PC;
        @(negedge Clk);

        // Reset state.
        step(0, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        chk("rst_count", 32'(BufCount), 32'd0);
        chk("rst_valid", 32'(InstrValid), 32'd0);
        chk("rst_addr", ImemAddress, 32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);

        // Streaming with decode always ready.
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 0, 0, 32'h0);
            chk("seq_pc", InstrPC, 32'(4 * i));
            chk("seq_cnt", 32'(BufCount), 32'd1);
        end

        // Backpressure saturates the buffer, then drains in order.
        step(0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h0);
        chk("bp_cnt", 32'(BufCount), 32'd2);
        chk("bp_addr", ImemAddress, 32'd8);
        for (int i = 0; i < 3; i++) begin
            chk("bp_drain_pc", InstrPC, 32'(4 * i));
            step(1, 1, 0, 0, 32'h0);
        end

        // Redirect with a full buffer and an unaligned target.
        step(1, 0, 0, 0, 32'h0);
        chk("rd_full", 32'(BufCount), 32'd2);
        step(1, 0, 0, 1, 32'h0000_0033);
        chk("rd_cnt", 32'(BufCount), 32'd0);
        chk("rd_addr", ImemAddress, 32'h30);
        step(1, 0, 0, 0, 32'h0);
        chk("rd_first", InstrPC, 32'h30);
        chk("rd_valid", 32'(InstrValid), 32'd1);

        // Halt drains the buffer and freezes the fetch address.
        step(1, 0, 0, 0, 32'h0);
        chk("h_full", 32'(BufCount), 32'd2);
        frozen = 32'h38;
        step(1, 1, 1, 0, 32'h0);
        chk("h_pop1", 32'(BufCount), 32'd1);
        step(1, 1, 1, 0, 32'h0);
        chk("h_empty", 32'(InstrValid), 32'd0);
        step(1, 1, 1, 0, 32'h0);
        chk("h_frozen", ImemAddress, frozen);
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        chk("h_resume", InstrPC, frozen);

        // Run off the end of instruction memory.
        step(1, 1, 0, 1, 32'h0000_03FC);
        step(1, 1, 0, 0, 32'h0);
        chk("b_last", InstrPC, 32'h3FC);
        step(1, 1, 0, 0, 32'h0);
`ifdef FETCH_SEQUENCER_BOUNDS_CHECK_EN
        chk("b_fault", 32'(Fault), 32'd1);
        chk("b_nopush", 32'(BufCount), 32'd0);
`else
        chk("b_nofault", 32'(Fault), 32'd0);
        chk("b_past", InstrPC, 32'h400);
`endif
        step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h0);
        step(0, 1, 0, 0, 32'h0);
        chk("b_clear", 32'(Fault), 32'd0);

        // Reset wins over a redirect with a full buffer.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
        chk("r_full", 32'(BufCount), 32'd2);
        step(0, 0, 0, 1, 32'h100);
        chk("r_cnt", 32'(BufCount), 32'd0);
        chk("r_addr", ImemAddress, RST_PC);
        chk("r_valid", 32'(InstrValid), 32'd0);

        // Random traffic.
        hl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) hl = !hl;
            step($urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) != 0,
                 hl,
                 $urandom_range(0, 11) == 0,
                 32'($urandom_range(0, 2047)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: RESET_PC, 32'd0, fetch address loaded on reset; SHALL be word-aligned.
REQ-002 Port: Clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: Reset_n  in  1  reset, synchronous, active-low.
REQ-004 Port: ImemAddress  out  32  address to instruction memory; equals PC register.
REQ-005 Port: ImemInstruction  in  32  memory read data, valid combinationally in the same cycle as ImemAddress.
REQ-006 Port: RedirectValid  in  1  taken branch/jump from execute stage.
REQ-007 Port: RedirectTarget  in  32  new fetch address, sampled when RedirectValid=1.
REQ-008 Port: Halt  in  1  level; stop issuing new fetches while high.
REQ-009 Port: InstrValid  out  1  buffer head valid toward decode.
REQ-010 Port: InstrReady  in  1  decode accepts head when InstrValid=1.
REQ-011 Port: Instruction  out  32  buffer head instruction.
REQ-012 Port: InstrPC  out  32  address of buffer head instruction.
REQ-013 Port: BufCount  out  2  occupancy of fetch buffer, 0..2.
REQ-014 Port: Fault  out  1  out-of-range fetch flag (see Configuration).

Function
REQ-015 Block SHALL hold a 32-bit PC and a 2-entry FIFO of {instruction, pc} pairs.
REQ-016 Pop SHALL occur on a cycle with InstrValid=1 and InstrReady=1; InstrValid SHALL equal (BufCount!=0).
REQ-017 Fetch SHALL occur when state=RUN, RedirectValid=0, and (BufCount<2 or pop this cycle): ImemInstruction and PC pushed, PC<=PC+4.
REQ-018 Simultaneous push and pop SHALL leave BufCount unchanged and preserve order.
REQ-019 PC+4 SHALL wrap modulo 2^32.
REQ-020 RedirectValid=1 SHALL flush both entries (BufCount<=0), set PC<=RedirectTarget with bits [1:0] forced 0, perform no push that cycle; a handshake in the same cycle counts as completed.
REQ-021 Redirect SHALL take priority over Halt and fetch; first instruction at target SHALL appear with InstrValid=1 two cycles after redirect edge (one cycle fetch, visible next).
REQ-022 States: RUN, HALTED, FAULT; RUN->HALTED when Halt=1; HALTED->RUN when Halt=0; redirect in HALTED updates PC and flushes but state stays HALTED.
REQ-023 In HALTED and FAULT no pushes SHALL occur; remaining entries SHALL drain normally via pops.
REQ-024 Latency: first instruction SHALL be at buffer head, InstrValid=1, on the first edge after Reset_n deasserts with Halt=0.
REQ-025 Instruction/InstrPC SHALL be undefined-but-stable when InstrValid=0; decode SHALL ignore them.

Reset
REQ-026 Reset_n=0 at a rising edge SHALL set PC=RESET_PC, BufCount=0, state=RUN, Fault=0, InstrValid=0, regardless of any operation in flight.
REQ-027 During reset ImemAddress SHALL show RESET_PC after the first reset edge; no push SHALL occur on a reset edge.

Configuration
REQ-028 Macro FETCH_SEQUENCER_BOUNDS_CHECK_EN: when defined, a fetch attempt with PC >= IMEM_WORDS*4 SHALL not push, SHALL set Fault=1 and enter FAULT; FAULT exits only via reset.
REQ-029 Without the macro, Fault SHALL be tied 0, FAULT state SHALL not exist, and out-of-range PCs fetch whatever memory returns.

Structure
REQ-030 Package mips_fetch_pkg SHALL hold IMEM_WORDS=256, NOP encoding 32'h2000_0000, state enum type, and fetch-entry struct type.
REQ-031 The 2-entry FIFO SHALL be a sub-module fetch_buffer (push, pop, flush, count); state machine and PC stay in fetch_sequencer.

Verification
REQ-032 Reset release, InstrReady=1, Halt=0 -> InstrPC sequence 0,4,8,12 on consecutive cycles, BufCount steady 1.
REQ-033 InstrReady=0 for 5 cycles -> BufCount saturates at 2, PC stops at 8, ImemAddress=8; InstrReady=1 -> InstrPC 0,4,8 in order, no loss or duplicate.
REQ-034 Redirect to 32'h0000_0033 with BufCount=2 -> BufCount=0 next cycle, PC=0x30, next InstrPC=0x30.
REQ-035 Halt=1 with BufCount=2, InstrReady=1 -> two pops then InstrValid=0, ImemAddress frozen; Halt=0 -> fetch resumes at frozen PC.
REQ-036 Macro defined, redirect to 0x3FC then run -> instruction at 0x3FC delivered, Fault=1 at PC=0x400, no further pushes; Reset_n=0 clears Fault.
REQ-037 Reset_n=0 asserted mid-stream with BufCount=2 and RedirectValid=1 -> next cycle BufCount=0, PC=RESET_PC, InstrValid=0.
